// File: rtl/jtag_mode_switch_ctrl_pkg.sv
// Shared types for the JTAG/cJTAG mode-switch sequencer.
// Used by jtag_mode_switch_ctrl (optional stats: JTAG_MODE_SWITCH_STATS_EN).
package jtag_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        QUIESCE,
        RESET_SEQ,
        SWITCH,
        SETTLE,
        DONE
    } mode_sw_state_e;

    localparam logic MODE_JTAG  = 1'b0;
    localparam logic MODE_CJTAG = 1'b1;

endpackage

// File: rtl/jtag_mode_switch_ctrl_tck_pulse_gen.sv
// Generates a burst of PULSES TCK pulses (low half first) after a start strobe.
// o_done is asserted combinationally in the last cycle of the final high half.
module tck_pulse_gen #(
    parameter int TCK_HALF = 4,
    parameter int PULSES   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_tck,
    output logic o_done
);

    localparam int HW = $clog2(TCK_HALF + 1);
    localparam int PW = $clog2(PULSES + 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(TCK_HALF - 1);
    localparam logic [PW-1:0] PULSE_LAST = PW'(PULSES - 1);

    logic          r_active;
    logic [HW-1:0] r_half;
    logic [PW-1:0] r_pulse;
    logic          r_tck;
    logic          w_half_end;

    assign w_half_end = r_active && (r_half == HALF_LAST);
    assign o_done     = w_half_end && r_tck && (r_pulse == PULSE_LAST);
    assign o_tck      = r_tck;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_half   <= '0;
            r_pulse  <= '0;
            r_tck    <= 1'b0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_half   <= '0;
            r_pulse  <= '0;
            r_tck    <= 1'b0;
        end else if (w_half_end) begin
            r_half <= '0;
            r_tck  <= ~r_tck;
            // a pulse completes on its falling edge
            if (r_tck) begin
                if (r_pulse == PULSE_LAST) begin
                    r_active <= 1'b0;
                end else begin
                    r_pulse <= r_pulse + PW'(1);
                end
            end
        end else if (r_active) begin
            r_half <= r_half + HW'(1);
        end
    end

endmodule

// File: rtl/jtag_mode_switch_ctrl.sv
// Sequencer owning the JTAG/cJTAG mode select: quiesce, TAP reset, flip, settle.
// Optional macro JTAG_MODE_SWITCH_STATS_EN adds switch/abort counters.
module jtag_mode_switch_ctrl
    import jtag_ctrl_pkg::*;
#(
    parameter logic MODE_RESET       = MODE_JTAG,
    parameter int   QUIET_CYCLES     = 64,
    parameter int   MAX_WAIT         = 4096,
    parameter int   TCK_HALF         = 4,
    parameter int   RESET_TCK_PULSES = 5,
    parameter int   SETTLE_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_mode,
    output logic        req_ready,
    input  logic        jtag_clk_mon,
    output logic        mode_select,
    output logic        tap_override,
    output logic        ovr_tck,
    output logic        ovr_tms,
    output logic        busy,
    output logic        switch_done,
    output logic        abort_err
`ifdef JTAG_MODE_SWITCH_STATS_EN
   ,output logic [15:0] switch_count,
    output logic [15:0] abort_count
`endif
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [QW-1:0] QUIET_MAX   = QW'(QUIET_CYCLES);
    localparam logic [WW-1:0] WAIT_MAX    = WW'(MAX_WAIT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    mode_sw_state_e r_state;
    mode_sw_state_e w_next;

    logic          r_mon_s1;
    logic          r_mon_s2;
    logic          r_mon_s3;
    logic          w_mon_edge;
    logic [QW-1:0] r_quiet;
    logic [WW-1:0] r_wait;
    logic [SW-1:0] r_settle;
    logic          r_req_mode;
    logic          r_req_ready;
    logic          r_mode_select;
    logic          r_tap_override;
    logic          r_ovr_tms;
    logic          r_busy;
    logic          r_switch_done;
    logic          r_abort_err;
    logic          w_accept;
    logic          w_noop;
    logic          w_abort;
    logic          w_gen_start;
    logic          w_gen_done;
    logic          w_gen_tck;

    // monitored clock is asynchronous: synchronize, then detect either edge
    always_ff @(posedge clk) begin
        r_mon_s1 <= jtag_clk_mon;
        r_mon_s2 <= r_mon_s1;
        r_mon_s3 <= r_mon_s2;
    end

    assign w_mon_edge  = r_mon_s2 ^ r_mon_s3;
    assign w_accept    = req_valid & r_req_ready;
    assign w_gen_start = (r_state == QUIESCE) && (w_next == RESET_SEQ);

    tck_pulse_gen #(
        .TCK_HALF (TCK_HALF),
        .PULSES   (RESET_TCK_PULSES)
    ) u_tck_gen (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_gen_start),
        .o_tck   (w_gen_tck),
        .o_done  (w_gen_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_noop  = 1'b0;
        w_abort = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (req_mode == r_mode_select) begin
                        w_noop = 1'b1;
                    end else begin
                        w_next = QUIESCE;
                    end
                end
            end
            QUIESCE: begin
                // quiet wins if the timeout expires in the same cycle
                if (r_quiet == QUIET_MAX) begin
                    w_next = RESET_SEQ;
                end else if (r_wait == WAIT_MAX) begin
                    w_next  = IDLE;
                    w_abort = 1'b1;
                end
            end
            RESET_SEQ: begin
                if (w_gen_done) begin
                    w_next = SWITCH;
                end
            end
            SWITCH: w_next = SETTLE;
            SETTLE: begin
                if (r_settle == SETTLE_LAST) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != QUIESCE)) begin
            r_quiet <= '0;
            r_wait  <= '0;
        end else begin
            if (w_mon_edge) begin
                r_quiet <= '0;
            end else if (r_quiet != QUIET_MAX) begin
                r_quiet <= r_quiet + QW'(1);
            end
            if (r_wait != WAIT_MAX) begin
                r_wait <= r_wait + WW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state != SETTLE)) begin
            r_settle <= '0;
        end else if (r_settle != SETTLE_LAST) begin
            r_settle <= r_settle + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_mode     <= MODE_RESET;
            r_req_ready    <= 1'b0;
            r_mode_select  <= MODE_RESET;
            r_tap_override <= 1'b0;
            r_ovr_tms      <= 1'b1;
            r_busy         <= 1'b0;
            r_switch_done  <= 1'b0;
            r_abort_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_mode <= req_mode;
            end
            if (r_state == SWITCH) begin
                r_mode_select <= r_req_mode;
            end
            r_req_ready    <= (w_next == IDLE) && !w_accept && !w_abort;
            r_tap_override <= (w_next == RESET_SEQ) || (w_next == SWITCH) ||
                              (w_next == SETTLE);
            r_ovr_tms      <= 1'b1;
            r_busy         <= (w_next != IDLE);
            r_switch_done  <= w_noop || (w_next == DONE);
            r_abort_err    <= w_abort;
        end
    end

    assign req_ready    = r_req_ready;
    assign mode_select  = r_mode_select;
    assign tap_override = r_tap_override;
    assign ovr_tck      = w_gen_tck;
    assign ovr_tms      = r_ovr_tms;
    assign busy         = r_busy;
    assign switch_done  = r_switch_done;
    assign abort_err    = r_abort_err;

`ifdef JTAG_MODE_SWITCH_STATS_EN
    logic [15:0] r_switch_count;
    logic [15:0] r_abort_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_switch_count <= '0;
            r_abort_count  <= '0;
        end else begin
            if ((w_next == DONE) && (r_switch_count != 16'hFFFF)) begin
                r_switch_count <= r_switch_count + 16'd1;
            end
            if (w_abort && (r_abort_count != 16'hFFFF)) begin
                r_abort_count <= r_abort_count + 16'd1;
            end
        end
    end

    assign switch_count = r_switch_count;
    assign abort_count  = r_abort_count;
`endif

endmodule

// File: tb/tb_jtag_mode_switch_ctrl.sv
// Bench for jtag_mode_switch_ctrl: directed plus random requests/monitor activity
// against a timeline model; counters checked when JTAG_MODE_SWITCH_STATS_EN is set.
module tb_jtag_mode_switch_ctrl;

    localparam int   Q  = 64;
    localparam int   MW = 4096;
    localparam int   H  = 4;
    localparam int   P  = 5;
    localparam int   S  = 16;
    localparam int   RS = 2 * H * P;
    localparam logic MR = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic req_mode;
    logic req_ready;
    logic mon;
    logic mode_select;
    logic tap_override;
    logic ovr_tck;
    logic ovr_tms;
    logic busy;
    logic switch_done;
    logic abort_err;
`ifdef JTAG_MODE_SWITCH_STATS_EN
    logic [15:0] switch_count;
    logic [15:0] abort_count;
    int exp_sw = 0;
    int exp_ab = 0;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   tog_q[$];
    logic cur_mode;
    int   last_done_k;
    int   last_ovr_k;

    jtag_mode_switch_ctrl #(
        .MODE_RESET       (MR),
        .QUIET_CYCLES     (Q),
        .MAX_WAIT         (MW),
        .TCK_HALF         (H),
        .RESET_TCK_PULSES (P),
        .SETTLE_CYCLES    (S)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .jtag_clk_mon (mon),
        .mode_select  (mode_select),
        .tap_override (tap_override),
        .ovr_tck      (ovr_tck),
        .ovr_tms      (ovr_tms),
        .busy         (busy),
        .switch_done  (switch_done),
        .abort_err    (abort_err)
`ifdef JTAG_MODE_SWITCH_STATS_EN
       ,.switch_count (switch_count),
        .abort_count  (abort_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {req_ready, mode_select, tap_override, ovr_tck,
                ovr_tms, busy, switch_done, abort_err};
    endfunction

    function automatic logic [7:0] pk(input logic r, input logic m,
                                      input logic o, input logic t,
                                      input logic s, input logic b,
                                      input logic d, input logic a);
        return {r, m, o, t, s, b, d, a};
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%b expected=%b (rdy,mode,ovr,tck,tms,busy,done,abort)",
                   tag, k, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef JTAG_MODE_SWITCH_STATS_EN
        chk_int({tag, "_swcnt"}, int'(switch_count), exp_sw);
        chk_int({tag, "_abcnt"}, int'(abort_count), exp_ab);
`else
        chk_int({tag, "_nostat_mode"}, int'(mode_select), int'(cur_mode));
`endif
    endtask

    // Takeover edge after acceptance: QUIET_CYCLES + 1 edges after the last
    // activity the controller could have seen (a toggle is seen 3 edges later).
    // Returns 0 when MAX_WAIT expires first.
    function automatic int takeover_edge();
        int last_det = 0;
        for (int k = 1; k <= MW + 1; k++) begin
            foreach (tog_q[i]) begin
                if (tog_q[i] + 3 == k - 1) last_det = k - 1;
            end
            if ((k - 1) - last_det >= Q) return k;
        end
        return 0;
    endfunction

    // Expected outputs k edges after acceptance (t<0 no-op, t==0 abort).
    function automatic logic [7:0] expect_at(input int k, input int t,
                                             input logic m0, input logic m1);
        int fin;
        fin = t + RS + 1 + S;
        if (t < 0) begin
            if (k == 0) return pk(0, m0, 0, 0, 1, 0, 1, 0);
            return pk(1, m0, 0, 0, 1, 0, 0, 0);
        end
        if (t == 0) begin
            if (k < MW + 1)  return pk(0, m0, 0, 0, 1, 1, 0, 0);
            if (k == MW + 1) return pk(0, m0, 0, 0, 1, 0, 0, 1);
            return pk(1, m0, 0, 0, 1, 0, 0, 0);
        end
        if (k < t)       return pk(0, m0, 0, 0, 1, 1, 0, 0);
        if (k < t + RS)  return pk(0, m0, 1, 1'(((k - t) / H) % 2), 1, 1, 0, 0);
        if (k == t + RS) return pk(0, m0, 1, 0, 1, 1, 0, 0);
        if (k < fin)     return pk(0, m1, 1, 0, 1, 1, 0, 0);
        if (k == fin)    return pk(0, m1, 0, 0, 1, 1, 1, 0);
        return pk(1, m1, 0, 0, 1, 0, 0, 0);
    endfunction

    task automatic run_txn(input string tag, input logic m, input int rst_at);
        int   t;
        int   last;
        bit   noop;
        bit   hit;
        logic m0;
        m0   = cur_mode;
        noop = (m === cur_mode);
        t    = noop ? -1 : takeover_edge();
        last = noop ? 2 : ((t == 0) ? MW + 3 : t + RS + 1 + S + 2);
        last_done_k = -1;
        last_ovr_k  = -1;
        chk({tag, "_pre"}, -1, {7'd0, req_ready}, 8'd1);
        req_valid = 1'b1;
        req_mode  = m;
        step();
        req_valid = 1'b0;
        req_mode  = ~m;
        for (int k = 0; k <= last; k++) begin
            chk(tag, k, outs(), expect_at(k, t, m0, m));
            if (switch_done === 1'b1 && last_done_k < 0) last_done_k = k;
            if (tap_override === 1'b1 && last_ovr_k < 0) last_ovr_k = k;
            if (k == rst_at) begin
                rst = 1'b1;
                step();
                chk({tag, "_inrst"}, k + 1, outs(), pk(0, MR, 0, 0, 1, 0, 0, 0));
                rst = 1'b0;
                step();
                chk({tag, "_postrst"}, k + 2, outs(), pk(1, MR, 0, 0, 1, 0, 0, 0));
                cur_mode = MR;
`ifdef JTAG_MODE_SWITCH_STATS_EN
                exp_sw = 0;
                exp_ab = 0;
`endif
                chk_stats(tag);
                tog_q.delete();
                repeat (4) step();
                return;
            end
            hit = 1'b0;
            foreach (tog_q[i]) if (tog_q[i] == k) hit = 1'b1;
            if (hit) mon = ~mon;
            if (k < last) step();
        end
        if (noop) begin
            chk_int({tag, "_done_lat"}, last_done_k, 0);
        end else if (t == 0) begin
            chk_int({tag, "_no_done"}, last_done_k, -1);
`ifdef JTAG_MODE_SWITCH_STATS_EN
            exp_ab++;
`endif
        end else begin
            chk_int({tag, "_done_lat"}, last_done_k, t + RS + 1 + S);
            cur_mode = m;
`ifdef JTAG_MODE_SWITCH_STATS_EN
            exp_sw++;
`endif
        end
        chk_stats(tag);
        tog_q.delete();
        repeat (4) step();
    endtask

    initial begin
        logic m;
        int   n;
        int   c;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_mode  = 1'b0;
        mon       = 1'b0;
        cur_mode  = MR;
        repeat (3) step();
        chk("reset", 0, outs(), pk(0, MR, 0, 0, 1, 0, 0, 0));
        rst = 1'b0;
        step();
        chk("rst_release", 1, outs(), pk(1, MR, 0, 0, 1, 0, 0, 0));
        chk_stats("reset");
        repeat (3) step();

        run_txn("noop0", 1'b0, -1);

        run_txn("sw_to_1", 1'b1, -1);
        chk_int("sw_total_cycles", last_done_k, 1 + Q + 2 * H * P + 1 + S);
        chk_int("sw_override_at", last_ovr_k, 1 + Q);

        for (int k = 5; k < MW + 8; k += 10) tog_q.push_back(k);
        run_txn("abort", 1'b0, -1);

        tog_q.push_back(40);
        run_txn("tog40", 1'b0, -1);
        chk_int("tog40_takeover", last_ovr_k, 40 + 3 + Q + 1);

        for (int r = 0; r < 10; r++) begin
            m = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 5);
            for (int j = 0; j < n; j++) begin
                c = $urandom_range(0, 250);
                tog_q.push_back(c);
            end
            run_txn("rand", m, -1);
        end

        run_txn("rst_mid", ~cur_mode, Q + 1 + 2 * 2 * H + 2);
        run_txn("after_rst", 1'b1, -1);
        run_txn("back_to_0", 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
